solution_collector: RTL and testbench

SOLUTION_COLLECTOR -- requirements
Module: solution_collector

---
 rtl/queens_pkg.sv | 14 +
 rtl/solution_collector_board_bank.sv | 45 ++++
 rtl/solution_collector.sv | 163 ++++++++++++++++
 tb/tb_solution_collector.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queens_pkg.sv
// Shared constants and types for the queens solution collector.
// Optional row check is enabled with macro ONEHOT_CHECK_EN.
package queens_pkg;

    localparam int BOARD_N   = 8;
    localparam int IDX_W     = 3;
    localparam int SOL_CNT_W = 7;

    typedef enum logic {
        R_IDLE,
        R_DRAIN
    } rd_state_e;

endpackage

// File: rtl/solution_collector_board_bank.sv
// One board of BOARD_N rows: synchronous write, combinational read,
// and a full flag.
module board_bank
    import queens_pkg::*;
#(
    parameter int N  = BOARD_N,
    parameter int IW = IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_i,
    input  logic [IW-1:0] widx_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic [N-1:0]  rdata_o,
    input  logic          set_i,
    input  logic          clr_i,
    output logic          full_o
);

    logic [N-1:0] mem_q [N];
    logic         full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            if (ld_i) begin
                mem_q[widx_i] <= wdata_i;
            end
            if (set_i) begin
                full_q <= 1'b1;
            end else if (clr_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];
    assign full_o  = full_q;

endmodule

// File: rtl/solution_collector.sv
// Ping-pong collector of N-queens boards from a solver to a row consumer.
// Define ONEHOT_CHECK_EN to flag accepted rows that are not one-hot.
module solution_collector #(
    parameter int BOARD_N = queens_pkg::BOARD_N
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [BOARD_N-1:0]              in_row,
    output logic                            in_ready,
    input  logic                            solver_done,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BOARD_N-1:0]              out_row,
    output logic [queens_pkg::IDX_W-1:0]    out_index,
    output logic                            out_last,
    output logic [queens_pkg::SOL_CNT_W-1:0] sol_count,
    output logic                            done,
    output logic                            err
);

    import queens_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(BOARD_N - 1);

    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    rd_state_e            state_q, state_d;
    logic [SOL_CNT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 seen_q, seen_d;
    logic                 done_q, done_d;

    logic [1:0]           full, ld, set, clr;
    logic [BOARD_N-1:0]   rdata [2];
    logic                 acc;
    logic                 rd_ok;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        board_bank #(
            .N  (BOARD_N),
            .IW (IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (reset),
            .ld_i    (ld[b]),
            .widx_i  (wr_idx_q),
            .wdata_i (in_row),
            .ridx_i  (rd_idx_q),
            .rdata_o (rdata[b]),
            .set_i   (set[b]),
            .clr_i   (clr[b]),
            .full_o  (full[b])
        );
    end

    always_comb begin
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        seen_d    = seen_q;
        ld        = '0;
        set       = '0;
        clr       = '0;

        in_ready  = !full[wr_bank_q] && !done_q;
        acc       = in_valid && in_ready;
        rd_ok     = full[rd_bank_q];

        if (acc) begin
            ld[wr_bank_q] = 1'b1;
        end

        // A finish pulse overrides any row arriving alongside it.
        if (solver_done) begin
            seen_d = 1'b1;
            if (wr_idx_q != '0) begin
                err_d    = 1'b1;
                wr_idx_d = '0;
            end
        end else if (acc) begin
            if (wr_idx_q == LAST) begin
                wr_idx_d       = '0;
                set[wr_bank_q] = 1'b1;
                wr_bank_d      = !wr_bank_q;
                if (cnt_q == {SOL_CNT_W{1'b1}}) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

`ifdef ONEHOT_CHECK_EN
        if (acc && ((in_row == '0) ||
                    ((in_row & (in_row - BOARD_N'(1))) != '0))) begin
            err_d = 1'b1;
        end
`endif

        unique case (state_q)
            R_IDLE:  if (rd_ok) state_d = R_DRAIN;
            R_DRAIN: state_d = R_DRAIN;
            default: state_d = R_IDLE;
        endcase

        if (rd_ok && out_ready) begin
            if (rd_idx_q == LAST) begin
                clr[rd_bank_q] = 1'b1;
                rd_bank_d      = !rd_bank_q;
                rd_idx_d       = '0;
                state_d        = R_IDLE;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end

        done_d = done_q ||
                 (seen_q && (full == 2'b00) && (state_q == R_IDLE));

        out_valid = rd_ok;
        out_row   = rd_ok ? rdata[rd_bank_q] : '0;
        out_index = rd_ok ? rd_idx_q : '0;
        out_last  = rd_ok && (rd_idx_q == LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            seen_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            done_q    <= done_d;
        end
    end

    assign sol_count = cnt_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_solution_collector.sv
// Directed bench for solution_collector: capture, ping-pong, stall,
// partial finish, async reset, row check and count saturation.
module tb_solution_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_row;
    logic       in_ready;
    logic       solver_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_row;
    logic [2:0] out_index;
    logic       out_last;
    logic [6:0] sol_count;
    logic       done;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q_row [$];
    logic [2:0] q_idx [$];
    logic       q_last [$];

    logic [7:0] B1 [8] = '{8'h01, 8'h10, 8'h80, 8'h20,
                           8'h04, 8'h40, 8'h02, 8'h08};
    logic [7:0] B2 [8] = '{8'h80, 8'h08, 8'h01, 8'h40,
                           8'h02, 8'h20, 8'h04, 8'h10};
    logic [7:0] B3 [8] = '{8'h04, 8'h40, 8'h08, 8'h01,
                           8'h80, 8'h20, 8'h02, 8'h10};

    solution_collector #(.BOARD_N(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_row      (in_row),
        .in_ready    (in_ready),
        .solver_done (solver_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_index   (out_index),
        .out_last    (out_last),
        .sol_count   (sol_count),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees a stable handshake.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            q_row.push_back(out_row);
            q_idx.push_back(out_index);
            q_last.push_back(out_last);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic clear_q();
        q_row.delete();
        q_idx.delete();
        q_last.delete();
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        in_row      = '0;
        solver_done = 1'b0;
        out_ready   = 1'b0;
        reset       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_q();
    endtask

    // Called at posedge+1; returns at posedge+1 after the row is taken.
    task automatic push_row(input logic [7:0] r, output bit ok);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_row   = r;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ok       = got;
    endtask

    task automatic test_reset();
        in_valid    = 1'b0;
        in_row      = '0;
        solver_done = 1'b0;
        out_ready   = 1'b0;
        reset       = 1'b0;
        #3;
        vectors++;
        if ({out_valid, out_last, done, err} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b required 0000",
                     {out_valid, out_last, done, err});
            miscompares++;
        end
        vectors++;
        if ({out_row, out_index, sol_count} !== 18'h0) begin
            $display("FAIL reset_data: row %h idx %0d cnt %0d required 0",
                     out_row, out_index, sol_count);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
            miscompares++;
        end
        clear_q();
    endtask

    task automatic test_capture();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_row(B1[i], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL cap_push%0d: got timeout required accept", i);
                miscompares++;
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 3'd0) begin
            $display("FAIL cap_latency: valid %b idx %0d required 1 0",
                     out_valid, out_index);
            miscompares++;
        end
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (q_row.size() != 8) begin
            $display("FAIL cap_count: got %0d rows required 8", q_row.size());
            miscompares++;
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (q_row[i] !== B1[i] || q_idx[i] !== 3'(i) ||
                    q_last[i] !== (i == 7)) begin
                    $display("FAIL cap_row%0d: got %h/%0d/%b required %h/%0d/%b",
                             i, q_row[i], q_idx[i], q_last[i],
                             B1[i], i, (i == 7));
                    miscompares++;
                end
            end
        end
        vectors++;
        if (sol_count !== 7'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL cap_end: cnt %0d rdy %b val %b required 1 1 0",
                     sol_count, in_ready, out_valid);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_row(i < 8 ? B1[i] : B2[i-8], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL bp_push%0d: got timeout required accept", i);
                miscompares++;
            end
        end
        in_valid = 1'b1;
        in_row   = B3[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || sol_count !== 7'd2) begin
                $display("FAIL bp_stall%0d: rdy %b cnt %0d required 0 2",
                         c, in_ready, sol_count);
                miscompares++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_row(B3[i], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL bp_push3_%0d: got timeout required accept", i);
                miscompares++;
            end
        end
        repeat (30) @(posedge clk);
        #1;
        vectors++;
        if (q_row.size() != 24) begin
            $display("FAIL bp_count: got %0d rows required 24", q_row.size());
            miscompares++;
        end else begin
            for (int i = 0; i < 24; i++) begin
                exp = i < 8 ? B1[i] : (i < 16 ? B2[i-8] : B3[i-16]);
                vectors++;
                if (q_row[i] !== exp || q_idx[i] !== 3'(i % 8)) begin
                    $display("FAIL bp_row%0d: got %h/%0d required %h/%0d",
                             i, q_row[i], q_idx[i], exp, i % 8);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (sol_count !== 7'd3) begin
            $display("FAIL bp_sol_count: got %0d required 3", sol_count);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_row(B2[i], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL st_push%0d: got timeout required accept", i);
                miscompares++;
            end
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_index !== 3'd3 || out_row !== B2[3]) begin
                $display("FAIL st_hold%0d: got %b/%0d/%h required 1/3/%h",
                         c, out_valid, out_index, out_row, B2[3]);
                miscompares++;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (q_row.size() != 8) begin
            $display("FAIL st_count: got %0d rows required 8", q_row.size());
            miscompares++;
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (q_row[i] !== B2[i] || q_idx[i] !== 3'(i)) begin
                    $display("FAIL st_row%0d: got %h/%0d required %h/%0d",
                             i, q_row[i], q_idx[i], B2[i], i);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_partial();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_row(B1[i], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL pt_push%0d: got timeout required accept", i);
                miscompares++;
            end
        end
        solver_done = 1'b1;
        @(posedge clk);
        #1;
        solver_done = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || sol_count !== 7'd0) begin
            $display("FAIL pt_err: err %b cnt %0d required 1 0", err, sol_count);
            miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_row   = 8'h01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL pt_done%0d: done %b rdy %b required 1 0",
                         c, done, in_ready);
                miscompares++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (q_row.size() != 0 || sol_count !== 7'd0 || out_valid !== 1'b0) begin
            $display("FAIL pt_drain: rows %0d cnt %0d val %b required 0 0 0",
                     q_row.size(), sol_count, out_valid);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit found;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_row(B3[i], ok);
            vectors++;
            if (!ok) begin
                $display("FAIL ar_push%0d: got timeout required accept", i);
                miscompares++;
            end
        end
        out_ready = 1'b1;
        found     = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_index == 3'd4) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            $display("FAIL ar_reach4: got timeout required out_index 4");
            miscompares++;
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_index !== 3'd0 || sol_count !== 7'd0) begin
            $display("FAIL ar_async: val %b idx %0d cnt %0d required 0 0 0",
                     out_valid, out_index, sol_count);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_q();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || sol_count !== 7'd0) begin
            $display("FAIL ar_release: rdy %b cnt %0d required 1 0",
                     in_ready, sol_count);
            miscompares++;
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (q_row.size() != 0 || out_valid !== 1'b0) begin
            $display("FAIL ar_no_output: rows %0d val %b required 0 0",
                     q_row.size(), out_valid);
            miscompares++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_onehot();
        bit ok;
        logic exp_err;
`ifdef ONEHOT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        push_row(8'h03, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL oh_push: got timeout required accept");
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (err !== exp_err) begin
            $display("FAIL oh_err: got %b required %b", err, exp_err);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        bit ok;
        bit all_ok;
        do_reset();
        out_ready = 1'b1;
        all_ok    = 1'b1;
        for (int b = 0; b < 127; b++) begin
            for (int i = 0; i < 8; i++) begin
                push_row(B1[i], ok);
                if (!ok) all_ok = 1'b0;
            end
        end
        vectors++;
        if (!all_ok) begin
            $display("FAIL sat_push: got timeout required accept");
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (sol_count !== 7'd127 || err !== 1'b0) begin
            $display("FAIL sat_127: cnt %0d err %b required 127 0",
                     sol_count, err);
            miscompares++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            push_row(B2[i], ok);
            if (!ok) all_ok = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (sol_count !== 7'd127 || err !== 1'b1 || !all_ok) begin
            $display("FAIL sat_128: cnt %0d err %b required 127 1",
                     sol_count, err);
            miscompares++;
        end
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (q_row.size() != 1024) begin
            $display("FAIL sat_drain: got %0d rows required 1024", q_row.size());
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_backpressure();
        test_stall();
        test_partial();
        test_async_reset();
        test_onehot();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
